// File: rtl/acc_bank.sv
// acc_bank: bank of DEPTH accumulators with load/add/sub/clear writes, two read ports and a clear sweep
module acc_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_mode,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              clr_start,
    output logic              busy,
    output logic              ovf,
    output logic              wr_err
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic              ovf_q, ovf_d, wr_err_q, wr_err_d;
    logic              wr_ok;
    logic [WIDTH-1:0]  cur;
    logic [WIDTH:0]    sum, diff;

    // Extra top bit of sum/diff is the carry (add) or unsigned borrow (sub).
    assign wr_ok = wr_en && state_q == IDLE && ({1'b0, wr_addr} < DEPTH_C);
    assign cur   = wr_ok ? mem_q[wr_addr] : '0;
    assign sum   = {1'b0, cur} + {1'b0, wr_data};
    assign diff  = {1'b0, cur} - {1'b0, wr_data};

    assign rd_data_a = ({1'b0, rd_addr_a} < DEPTH_C) ? mem_q[rd_addr_a] : '0;
    assign rd_data_b = ({1'b0, rd_addr_b} < DEPTH_C) ? mem_q[rd_addr_b] : '0;
    assign ovf       = ovf_q;
    assign wr_err    = wr_err_q;

    // Sweep FSM state and pointer; reset aborts a running sweep at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Sweep next state: start on clr_start, finish after clearing the last entry.
    always_comb begin
        state_d   = state_q == IDLE ? (clr_start ? CLEAR : IDLE) : (clr_ptr_q == LAST ? IDLE : CLEAR);
        clr_ptr_d = state_q == IDLE ? '0 : clr_ptr_q + ADDR_W'(1);
    end

    // Sweep outputs.
    always_comb begin
        busy = state_q == CLEAR;
    end

    // Array and flag next state: the sweep clear is applied after the write, so it wins.
    always_comb begin
        mem_d    = mem_q;
        ovf_d    = ovf_q;
        wr_err_d = wr_en && state_q == CLEAR;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_mode == 2'b00 ? wr_data :
                             wr_mode == 2'b01 ? sum[WIDTH-1:0] :
                             wr_mode == 2'b10 ? diff[WIDTH-1:0] : '0;
            ovf_d          = wr_mode == 2'b01 ? sum[WIDTH] :
                             wr_mode == 2'b10 ? diff[WIDTH] : 1'b0;
        end
        if (state_q == CLEAR)
            mem_d[clr_ptr_q] = '0;
    end

    // Accumulator array and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            ovf_q    <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            ovf_q    <= ovf_d;
            wr_err_q <= wr_err_d;
        end
    end
endmodule
